// File: rtl/seq_divider_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// Signal names follow the divider's own port list.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per clock, with sign fix-up.
// Results: quotient (ALU low word) and remainder (ALU high word).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         clr,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_signed;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_prem;
    logic [WIDTH-1:0]   r_wquot;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic [WIDTH-1:0]   w_mag_dividend;
    logic [WIDTH-1:0]   w_mag_divisor;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_next_prem;
    logic               w_neg_q;
    logic               w_neg_r;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_mag_dividend = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_mag_divisor  = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // The shifted remainder is WIDTH+1 bits; a successful trial always leaves less than the divisor.
    assign w_shift     = {r_prem, r_wquot[WIDTH-1]};
    assign w_fits      = (w_shift >= {1'b0, r_dvsr});
    assign w_diff      = w_shift[WIDTH-1:0] - r_dvsr;
    assign w_next_prem = w_fits ? w_diff : w_shift[WIDTH-1:0];

    assign w_neg_q = r_signed & (r_neg_a ^ r_neg_b);
    assign w_neg_r = r_signed & r_neg_a;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_prem      <= '0;
            r_wquot     <= '0;
            r_dvsr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_signed <= bus.signed_op;
                        r_neg_a  <= bus.signed_op & bus.dividend[WIDTH-1];
                        r_neg_b  <= bus.signed_op & bus.divisor[WIDTH-1];
                        r_dvsr   <= w_mag_divisor;
                        r_prem   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        // Zero divisor keeps the raw dividend so it can be reported as the remainder.
                        if (bus.divisor == '0) begin
                            r_wquot <= bus.dividend;
                            r_state <= S_DONE;
                        end else begin
                            r_wquot <= w_mag_dividend;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_prem  <= w_next_prem;
                    r_wquot <= {r_wquot[WIDTH-2:0], w_fits};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quotient  <= w_neg_q ? -r_wquot : r_wquot;
                    r_remainder <= w_neg_r ? -r_prem  : r_prem;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_DONE;
                end
                default: begin
                    // Still busy here means we arrived straight from IDLE on a zero divisor.
                    if (r_busy) begin
                        r_quotient  <= '1;
                        r_remainder <= r_wquot;
                        r_dbz       <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an integer-arithmetic reference.
module tb_seq_divider;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q = qq[31:0]; r = rr[31:0]; dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input bit inject, input string tag);
        logic [31:0] eq, er, q, r;
        bit edz, dz0;
        logic dz;
        int exp_lat, lat, busy_cyc, done_cnt, busy_after;
        model(a, b, s, eq, er, edz);
        exp_lat = edz ? 1 : 33;
        lat = -1; busy_cyc = 0; done_cnt = 0; busy_after = 0;
        q = '0; r = '0; dz = 1'b0; dz0 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.signed_op = 1'($urandom_range(0, 1));
        bus.dividend = $urandom; bus.divisor = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (k == 0) dz0 = bus.div_by_zero;
            if (bus.busy) busy_cyc++;
            if (lat >= 0 && k > lat && bus.busy) busy_after++;
            if (bus.done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k; q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
                end
            end
            bus.start = inject && (k == 4 || k == 19 || bus.done);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        $display("div %s a=%h b=%h s=%0d q=%h r=%h dz=%0d lat=%0d", tag, a, b, s, q, r, dz, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat); end
        checks++; if (busy_cyc !== exp_lat) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cyc, exp_lat); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt); end
        checks++; if (q !== eq) begin errors++; $display("FAIL %s quotient got %h want %h", tag, q, eq); end
        checks++; if (r !== er) begin errors++; $display("FAIL %s remainder got %h want %h", tag, r, er); end
        checks++; if (dz !== edz) begin errors++; $display("FAIL %s div_by_zero got %0d want %0d", tag, dz, edz); end
        checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL %s dbz_clear_on_start got %0d want 0", tag, dz0); end
        checks++; if (busy_after !== 0) begin errors++; $display("FAIL %s busy_after_done got %0d want 0", tag, busy_after); end
        checks++; if (bus.quotient !== eq || bus.remainder !== er) begin
            errors++; $display("FAIL %s hold got %h/%h want %h/%h", tag, bus.quotient, bus.remainder, eq, er);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 ||
            bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk); clr = 1'b0;
        $display("reset released");
    endtask

    task automatic test_unsigned();
        run_one(32'd100, 32'd7, 1'b0, 1'b0, "u_100_7");
        run_one(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "u_max_1");
        run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_min_m1");
    endtask

    task automatic test_signed();
        run_one(-32'sd100, 32'd7, 1'b1, 1'b0, "s_m100_7");
        run_one(32'd100, -32'sd7, 1'b1, 1'b0, "s_100_m7");
        run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_overflow");
    endtask

    task automatic test_div_by_zero();
        run_one(32'h1234_5678, 32'd0, 1'b0, 1'b0, "dbz");
        run_one(32'd50, 32'd5, 1'b0, 1'b0, "after_dbz");
    endtask

    task automatic test_back_to_back();
        run_one(32'hDEAD_BEEF, 32'd1234, 1'b0, 1'b1, "ignore_start");
        run_one(32'd7, 32'd100, 1'b1, 1'b0, "b2b_small");
    endtask

    task automatic test_reset_mid_op();
        int done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 ||
            bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk); clr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        $display("midop reset abandoned op, activity=%0d", done_seen);
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL midop_no_done got %0d want 0", done_seen); end
        run_one(32'd81, 32'd9, 1'b0, 1'b0, "after_clr");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit s;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (i % 7 == 3) b = 32'd0;
            run_one(a, b, s, 1'b0, "random");
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider that feeds the ALU's division path.
- Computes quotient and remainder one bit per clock, replacing a single-cycle combinational divide.
- Result is presented as a 64-bit pair: remainder in the high word, quotient in the low word. This matches the ALU high/low result convention consumed by the Z register pair.
- Start/busy/done handshake lets the control unit stall the datapath while a divide is in flight.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clr  input  1  asynchronous, active-high reset.
start  input  1  request a divide; sampled only in IDLE.
signed_op  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
dividend  input  WIDTH  numerator; captured on the accepting edge.
divisor  input  WIDTH  denominator; captured on the accepting edge.
busy  output  1  high from the accepting edge until done is asserted.
done  output  1  single-cycle pulse when results are valid.
quotient  output  WIDTH  registered quotient (destined for the ALU low word).
remainder  output  WIDTH  registered remainder (destined for the ALU high word).
div_by_zero  output  1  set with done when divisor was 0; held until next accepted start.

Behaviour:
- Reset (clr=1, any time, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and working registers cleared. Any in-flight divide is abandoned; no done pulse follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge E0: capture signed_op, the sign of each operand, and the magnitudes |dividend| and |divisor|. Magnitudes are taken only when signed_op=1; unsigned operands are used raw.
  - Also at E0: clear partial remainder, count=0, busy=1, div_by_zero=0.
  - Next state is RUN if divisor != 0, else DONE.
  - start=0: remain in IDLE, outputs hold.
- RUN: each edge performs one restoring step:
  - shift {partial_rem, work_quot} left by 1;
  - trial-subtract the divisor magnitude from the (WIDTH+1)-bit partial remainder;
  - if non-negative, keep the difference and set quotient LSB=1; otherwise restore and set quotient LSB=0.
  - count increments each step; after the WIDTH-th step (edge E32 for WIDTH=32), go to FIX.
- FIX (one edge, E33):
  - quotient is negated if signed_op and the operand signs differ.
  - remainder is negated if signed_op and the dividend was negative (remainder takes the dividend's sign).
  - Write the quotient and remainder output registers; set done=1, busy=0; go to DONE.
- Divide-by-zero path: at the edge after E0 (E1), quotient=all ones, remainder=raw dividend, div_by_zero=1, done=1, busy=0; go to DONE.
- DONE: done deasserts on the next edge; return to IDLE. A start seen while in DONE is ignored.
- Latency: normal divide, done is high in the cycle following E33 (34 edges after acceptance, counting E0). Divide-by-zero, done is high in the cycle following E1.
- start while busy=1 is ignored. Operand inputs may change freely after E0.
- Output registers hold their values until the next completion or clr.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient=0x80000000 and remainder=0. The wrap is natural; no flag is raised.
- The magnitude of -2^(WIDTH-1) is computed as unsigned 0x80000000 and must divide correctly in the WIDTH+1-bit datapath.
- Arithmetic is purely integer with truncation toward zero. Invariant when div_by_zero=0: dividend == quotient*divisor + remainder (mod 2^WIDTH).

Test Plan:
- Unsigned: start with 100/7, signed_op=0 -> done after 34 edges; quotient=14, remainder=2; busy high for exactly 33 cycles.
- Signed sign rules: -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100/-7 -> quotient=-14, remainder=2.
- Divide-by-zero: 0x12345678/0 -> done one cycle after acceptance; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. Next normal divide clears div_by_zero.
- Edge values: 0x80000000/0xFFFFFFFF signed -> quotient=0x80000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x80000000. 0xFFFFFFFF/1 unsigned -> quotient=0xFFFFFFFF, remainder=0.
- Handshake: pulse start again at cycles 5 and 20 of a busy divide with different operands -> ignored; the first result is unchanged and there is exactly one done pulse.
- Reset mid-op: assert clr at iteration 10 -> all outputs 0 immediately, no done pulse. After release, 81/9 runs normally and gives quotient=9, remainder=0.
